addr_bus_initiator: RTL and testbench

ADDR_BUS_INITIATOR -- requirements
Module: addr_bus_initiator

---
 rtl/addr_bus_initiator_pkg.sv | 32 +++
 rtl/addr_req_fifo.sv | 60 ++++++
 rtl/addr_bus_initiator.sv | 143 ++++++++++++++
 tb/tb_addr_bus_initiator.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/addr_bus_initiator_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// addr_bus_initiator_pkg: bus direction enum and FSM state encoding shared by
// the bus initiator and target-side address decoders.  Rev 1.0
// ----------------------------------------------------------------------------
package addr_bus_initiator_pkg;

  typedef enum logic [1:0] {
    READ         = 2'b00,
    WRITE        = 2'b01,
    READ_N_WRITE = 2'b10
  } dir_e;

  typedef logic [2:0] state_t;

  localparam logic [2:0] c_ST_IDLE      = 3'd0;
  localparam logic [2:0] c_ST_SETUP     = 3'd1;
  localparam logic [2:0] c_ST_RD_STROBE = 3'd2;
  localparam logic [2:0] c_ST_WR_STROBE = 3'd3;
  localparam logic [2:0] c_ST_HOLD      = 3'd4;

  // The unused encoding 2'b11 is folded onto READ.
  function automatic dir_e decode_dir(input logic [1:0] raw);
    case (raw)
      2'b01:   return WRITE;
      2'b10:   return READ_N_WRITE;
      default: return READ;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/addr_req_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// addr_req_fifo: request queue, registered storage, no write-through bypass.
// Rev 1.0
// ----------------------------------------------------------------------------
module addr_req_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           pop_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [c_PTR_W-1:0] wr_ptr_q;
  logic [c_PTR_W-1:0] rd_ptr_q;
  logic [c_CNT_W-1:0] count_q;
  logic               w_push;
  logic               w_pop;

  assign full_o     = (count_q == c_CNT_W'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign w_push     = push_i && !full_o;
  assign w_pop      = pop_i && !empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + c_PTR_W'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + c_PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + c_CNT_W'(1);
        2'b01:   count_q <= count_q - c_CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule
`default_nettype wire

// File: rtl/addr_bus_initiator.sv
`default_nettype none
// ----------------------------------------------------------------------------
// addr_bus_initiator: queued address/strobe bus master; optional address range
// rejection with ADDR_BUS_RANGE_CHECK_EN.  Rev 1.0
// ----------------------------------------------------------------------------
module addr_bus_initiator
  import addr_bus_initiator_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 4,
  parameter int FIFO_DEPTH    = 4,
  parameter int STROBE_CYCLES = 1,
  parameter int NUM_TARGETS   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDRESS_WIDTH-1:0] req_address,
  input  logic [1:0]               req_direction,
  output logic [ADDRESS_WIDTH-1:0] active_address,
  output logic                     read_enable,
  output logic                     write_enable,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int c_ENTRY_W = ADDRESS_WIDTH + 2;
  localparam int c_CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int c_STB_W   = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
  localparam logic [c_STB_W-1:0] c_STB_LAST = c_STB_W'(STROBE_CYCLES - 1);

  if (NUM_TARGETS < 1 || NUM_TARGETS > (1 << ADDRESS_WIDTH) ||
      FIFO_DEPTH < 2 || STROBE_CYCLES < 1) begin : g_bad_params
    $error("addr_bus_initiator: illegal parameter combination");
  end

  state_t                   state_q, state_d;
  logic [c_STB_W-1:0]       stb_cnt_q, stb_cnt_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  dir_e                     dir_q, dir_d;
  logic                     w_hs, w_push, w_pop, w_full, w_empty, w_stb_last;
  logic [c_CNT_W-1:0]       w_count;
  logic [c_ENTRY_W-1:0]     w_head;

  assign req_ready = ~w_full;
  assign w_hs      = req_valid && req_ready;

`ifdef ADDR_BUS_RANGE_CHECK_EN
  localparam logic [ADDRESS_WIDTH:0] c_NUM_TARGETS = (ADDRESS_WIDTH + 1)'(NUM_TARGETS);
  logic w_in_range;
  logic err_q;

  assign w_in_range = ({1'b0, req_address} < c_NUM_TARGETS);
  assign w_push     = w_hs && w_in_range;
  assign err        = err_q;

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= w_hs && !w_in_range;
  end
`else
  assign w_push = w_hs;
  assign err    = 1'b0;
`endif

  addr_req_fifo #(
    .WIDTH (c_ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (w_push),
    .push_data_i ({req_address, req_direction}),
    .pop_i       (w_pop),
    .pop_data_o  (w_head),
    .full_o      (w_full),
    .empty_o     (w_empty),
    .count_o     (w_count)
  );

  assign w_stb_last = (stb_cnt_q == c_STB_LAST);

  always_comb begin
    state_d   = state_q;
    stb_cnt_d = stb_cnt_q;
    addr_d    = addr_q;
    dir_d     = dir_q;
    w_pop     = 1'b0;
    case (state_q)
      c_ST_IDLE: begin
        if (!w_empty) begin
          w_pop   = 1'b1;
          addr_d  = w_head[c_ENTRY_W-1:2];
          dir_d   = decode_dir(w_head[1:0]);
          state_d = c_ST_SETUP;
        end
      end
      c_ST_SETUP: state_d = (dir_q == WRITE) ? c_ST_WR_STROBE : c_ST_RD_STROBE;
      c_ST_RD_STROBE: begin
        if (w_stb_last) begin
          stb_cnt_d = '0;
          state_d   = (dir_q == READ_N_WRITE) ? c_ST_WR_STROBE : c_ST_HOLD;
        end else begin
          stb_cnt_d = stb_cnt_q + c_STB_W'(1);
        end
      end
      c_ST_WR_STROBE: begin
        if (w_stb_last) begin
          stb_cnt_d = '0;
          state_d   = c_ST_HOLD;
        end else begin
          stb_cnt_d = stb_cnt_q + c_STB_W'(1);
        end
      end
      c_ST_HOLD: state_d = c_ST_IDLE;
      default:   state_d = c_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= c_ST_IDLE;
      stb_cnt_q <= '0;
      addr_q    <= '0;
      dir_q     <= READ;
    end else begin
      state_q   <= state_d;
      stb_cnt_q <= stb_cnt_d;
      addr_q    <= addr_d;
      dir_q     <= dir_d;
    end
  end

  // Bus outputs decode registered state only, so they are glitch-free.
  assign active_address = addr_q;
  assign read_enable    = (state_q == c_ST_RD_STROBE);
  assign write_enable   = (state_q == c_ST_WR_STROBE);
  assign done           = (state_q == c_ST_HOLD);
  assign busy           = (state_q != c_ST_IDLE) || (w_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_addr_bus_initiator.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_addr_bus_initiator: randomized and directed bench with a transaction-
// timeline reference model.  Rev 1.0
// ----------------------------------------------------------------------------
module tb_addr_bus_initiator;
  import addr_bus_initiator_pkg::*;

  localparam int AW    = 4;
  localparam int DEPTH = 4;
  localparam int S     = 2;
  localparam int NT    = 12;
  localparam int OW    = AW + 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic [AW-1:0] req_address = '0;
  logic [1:0]    req_direction = 2'b00;
  logic          req_ready, read_enable, write_enable, busy, done, err;
  logic [AW-1:0] active_address;
  logic [OW-1:0] obs;

  addr_bus_initiator #(
    .ADDRESS_WIDTH (AW),
    .FIFO_DEPTH    (DEPTH),
    .STROBE_CYCLES (S),
    .NUM_TARGETS   (NT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_address    (req_address),
    .req_direction  (req_direction),
    .active_address (active_address),
    .read_enable    (read_enable),
    .write_enable   (write_enable),
    .busy           (busy),
    .done           (done),
    .err            (err)
  );

  always #5 clk = ~clk;

  assign obs = {req_ready, busy, read_enable, write_enable, done, err, active_address};

  int vectors = 0;
  int miscompares = 0;

  // Reference model: pending queue plus phase index inside the current
  // transaction (0 = address setup, 1..strobes, last = done cycle, -1 = idle).
  int mq_addr[$];
  int mq_dir[$];
  int m_phase = -1;
  int m_len   = 0;
  int m_addr  = 0;
  int m_dir   = 0;
  bit m_err   = 1'b0;

  function automatic logic [OW-1:0] exp_vec();
    bit re, we, dn, rdy, bsy;
    re  = (m_phase >= 1) && (m_phase <= S) && (m_dir != 1);
    if (m_dir == 1)      we = (m_phase >= 1) && (m_phase <= S);
    else if (m_dir == 2) we = (m_phase > S) && (m_phase <= 2 * S);
    else                 we = 1'b0;
    dn  = (m_phase >= 0) && (m_phase == m_len - 1);
    rdy = (mq_addr.size() < DEPTH);
    bsy = (m_phase >= 0) || (mq_addr.size() > 0);
    return {rdy, bsy, re, we, dn, m_err, AW'(m_addr)};
  endfunction

  task automatic model_step(input bit r, input bit v, input int a, input int d);
    bit acc, ok;
    if (r) begin
      mq_addr.delete();
      mq_dir.delete();
      m_phase = -1;
      m_len   = 0;
      m_addr  = 0;
      m_dir   = 0;
      m_err   = 1'b0;
      return;
    end
    acc = v && (mq_addr.size() < DEPTH);
`ifdef ADDR_BUS_RANGE_CHECK_EN
    ok = (a < NT);
`else
    ok = 1'b1;
`endif
    if (m_phase >= 0) begin
      m_phase = (m_phase == m_len - 1) ? -1 : m_phase + 1;
    end else if (mq_addr.size() > 0) begin
      m_addr  = mq_addr.pop_front();
      m_dir   = mq_dir.pop_front();
      m_phase = 0;
      m_len   = 2 + S * ((m_dir == 2) ? 2 : 1);
    end
    if (acc && ok) begin
      mq_addr.push_back(a);
      mq_dir.push_back((d == 1) ? 1 : (d == 2) ? 2 : 0);
    end
    m_err = acc && !ok;
  endtask

  // Called at a falling edge: drive inputs, advance the model, wait one cycle.
  task automatic drive(input bit r, input bit v, input int a, input int d);
    rst           = r;
    req_valid     = v;
    req_address   = AW'(a);
    req_direction = d[1:0];
    model_step(r, v, a, d);
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 9, WRITE);
      vectors++;
      if (obs !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, AW'(0)}) begin
        miscompares++;
        $display("FAIL reset_state cyc=%0d got=%h exp=%h", i, obs, {1'b1, 5'b0, AW'(0)});
      end
    end
    drive(1'b0, 1'b0, 0, READ);
    vectors++;
    if (obs !== exp_vec()) begin
      miscompares++;
      $display("FAIL reset_release got=%h exp=%h", obs, exp_vec());
    end
  endtask

  task automatic test_single_write();
    int first_we = -1, done_at = -1, we_cnt = 0, re_cnt = 0, addr_at1 = -1;
    drive(1'b0, 1'b1, 5, WRITE);
    for (int j = 0; j < 12; j++) begin
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL single_write cyc=%0d got=%h exp=%h", j, obs, exp_vec());
      end
      if (j == 1) addr_at1 = int'(active_address);
      if (write_enable) begin we_cnt++; if (first_we < 0) first_we = j; end
      if (read_enable) re_cnt++;
      if (done && done_at < 0) done_at = j;
      drive(1'b0, 1'b0, 0, READ);
    end
    vectors++;
    if (addr_at1 !== 5 || first_we !== 2 || done_at !== 2 + S || we_cnt !== S || re_cnt !== 0) begin
      miscompares++;
      $display("FAIL single_write_timing got addr=%0d we_at=%0d done_at=%0d we=%0d re=%0d exp 5/2/%0d/%0d/0",
               addr_at1, first_we, done_at, we_cnt, re_cnt, 2 + S, S);
    end
  endtask

  task automatic test_read_n_write();
    int first_re = -1, first_we = -1, re_cnt = 0, we_cnt = 0, done_cnt = 0, overlap = 0;
    drive(1'b0, 1'b1, 3, READ_N_WRITE);
    for (int j = 0; j < 12; j++) begin
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL read_n_write cyc=%0d got=%h exp=%h", j, obs, exp_vec());
      end
      if (read_enable)  begin re_cnt++; if (first_re < 0) first_re = j; end
      if (write_enable) begin we_cnt++; if (first_we < 0) first_we = j; end
      if (read_enable && write_enable) overlap++;
      if (done) done_cnt++;
      drive(1'b0, 1'b0, 0, READ);
    end
    vectors++;
    if (re_cnt !== S || we_cnt !== S || overlap !== 0 || done_cnt !== 1 || first_we !== first_re + S) begin
      miscompares++;
      $display("FAIL read_n_write_shape got re=%0d we=%0d ovl=%0d done=%0d gap=%0d exp %0d/%0d/0/1/%0d",
               re_cnt, we_cnt, overlap, done_cnt, first_we - first_re, S, S, S);
    end
  endtask

  task automatic test_back_to_back();
    int exp_order[$];
    int issued[$];
    int addrs[5];
    int dirs[5];
    int n = 0;
    bit acc;
    for (int i = 0; i < 5; i++) begin
      addrs[i] = $urandom_range(0, NT - 1);
      dirs[i]  = $urandom_range(0, 2);
    end
    exp_order.push_back(10);
    for (int i = 0; i < 5; i++) exp_order.push_back(addrs[i]);
    drive(1'b0, 1'b1, 10, READ_N_WRITE);
    for (int c = 0; c < 80 && (n < 5 || busy); c++) begin
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL back_to_back cyc=%0d got=%h exp=%h", c, obs, exp_vec());
      end
      if (done) issued.push_back(int'(active_address));
      if (n < 5) begin
        acc = req_ready;
        drive(1'b0, 1'b1, addrs[n], dirs[n]);
        if (acc) begin
          n++;
          if (n == 4) begin
            vectors++;
            if (req_ready !== 1'b0) begin
              miscompares++;
              $display("FAIL full_ready got=%b exp=0", req_ready);
            end
          end
        end
      end else begin
        drive(1'b0, 1'b0, 0, READ);
      end
    end
    vectors++;
    if (issued.size() != 6 || n != 5) begin
      miscompares++;
      $display("FAIL back_to_back_count got issued=%0d accepted=%0d exp 6/5", issued.size(), n);
    end else begin
      for (int i = 0; i < 6; i++) begin
        vectors++;
        if (issued[i] !== exp_order[i]) begin
          miscompares++;
          $display("FAIL back_to_back_order idx=%0d got=%0d exp=%0d", i, issued[i], exp_order[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_strobe();
    int waited = 0;
    int strobes = 0, dones = 0;
    drive(1'b0, 1'b1, 1, READ);
    drive(1'b0, 1'b1, 2, READ);
    drive(1'b0, 1'b1, 4, READ);
    while (!read_enable && waited < 20) begin
      drive(1'b0, 1'b0, 0, READ);
      waited++;
    end
    vectors++;
    if (!read_enable) begin
      miscompares++;
      $display("FAIL mid_strobe_wait got read_enable=%b exp=1 within 20 cycles", read_enable);
    end
    drive(1'b1, 1'b0, 0, READ);
    vectors++;
    if (obs !== {1'b1, 5'b0, AW'(0)}) begin
      miscompares++;
      $display("FAIL mid_strobe_reset got=%h exp=%h", obs, {1'b1, 5'b0, AW'(0)});
    end
    for (int j = 0; j < 10; j++) begin
      drive(1'b0, 1'b0, 0, READ);
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL mid_strobe_after cyc=%0d got=%h exp=%h", j, obs, exp_vec());
      end
      if (read_enable || write_enable) strobes++;
      if (done) dones++;
    end
    vectors++;
    if (strobes !== 0 || dones !== 0) begin
      miscompares++;
      $display("FAIL mid_strobe_quiet got strobes=%0d done=%0d exp 0/0", strobes, dones);
    end
  endtask

  task automatic test_range_check();
    int errs = 0, wes = 0, dones = 0;
    int exp_errs, exp_wes, exp_dones;
`ifdef ADDR_BUS_RANGE_CHECK_EN
    exp_errs = 1; exp_wes = S; exp_dones = 1;
`else
    exp_errs = 0; exp_wes = 2 * S; exp_dones = 2;
`endif
    drive(1'b0, 1'b1, 13, WRITE);
    for (int j = 0; j < 16; j++) begin
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL range_check cyc=%0d got=%h exp=%h", j, obs, exp_vec());
      end
      if (err) errs++;
      if (write_enable) wes++;
      if (done) dones++;
      if (j == 0) drive(1'b0, 1'b1, 7, WRITE);
      else        drive(1'b0, 1'b0, 0, READ);
    end
    vectors++;
    if (errs !== exp_errs || wes !== exp_wes || dones !== exp_dones) begin
      miscompares++;
      $display("FAIL range_check_totals got err=%0d we=%0d done=%0d exp %0d/%0d/%0d",
               errs, wes, dones, exp_errs, exp_wes, exp_dones);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL random cyc=%0d got=%h exp=%h", c, obs, exp_vec());
      end
      if (c < 370)
        drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
              $urandom_range(0, (1 << AW) - 1), $urandom_range(0, 3));
      else
        drive(1'b0, 1'b0, 0, READ);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_write();
    test_read_n_write();
    test_back_to_back();
    test_reset_mid_strobe();
    test_range_check();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
